// File: rtl/cache_dir_requester.sv
// Requester-side directory controller: one core access at a time, lookup, hit/miss
// resolution, victim writeback, line fill and tag/state commit for one directory port.
package cache_pkg;
  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_E = 2'b10,
    ST_M = 2'b11
  } line_state_t;
endpackage

module cache_dir_requester
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic                   req_write,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [1:0]             rsp_state,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [31:0]            wb_addr,
  output logic                   fill_valid,
  input  logic                   fill_ready,
  output logic [31:0]            fill_addr,
  output logic                   fill_excl,
  input  logic                   fill_ack_valid,
  input  logic [1:0]             fill_ack_state,
  output logic [INDEX_WIDTH-1:0] dir_index,
  output logic [TAG_WIDTH-1:0]   dir_next_tag,
  output logic [1:0]             dir_next_state,
  output logic                   dir_write,
  input  logic [TAG_WIDTH-1:0]   dir_current_tag,
  input  logic [1:0]             dir_current_state
);
  localparam int OFFSET = 32 - TAG_WIDTH - INDEX_WIDTH;
  localparam logic [OFFSET-1:0] ZERO_OFFSET = '0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, WB, FILL_REQ, FILL_WAIT, UPDATE, RESP
  } fsm_t;

  fsm_t                   r_state, w_state_next;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_write;
  logic [TAG_WIDTH-1:0]   r_victim_tag;
  logic [1:0]             r_final_state;
  logic                   r_hit;

  logic [INDEX_WIDTH-1:0] w_req_index;
  logic                   w_hit;
  logic                   w_hit_path;
  logic                   w_unused_offset;

  assign w_req_index     = req_addr[OFFSET +: INDEX_WIDTH];
  assign w_unused_offset = ^req_addr[OFFSET-1:0];
  assign w_hit           = (dir_current_state != ST_I) && (dir_current_tag == r_tag);
  // A store hitting a Shared line needs ownership, so it leaves the hit path.
  assign w_hit_path      = w_hit && (!r_write || (dir_current_state != ST_S));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tag         <= '0;
      r_index       <= '0;
      r_write       <= 1'b0;
      r_victim_tag  <= '0;
      r_final_state <= ST_I;
      r_hit         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tag   <= req_addr[31 -: TAG_WIDTH];
            r_index <= w_req_index;
            r_write <= req_write;
            r_hit   <= 1'b0;
          end
        end
        COMPARE: begin
          r_victim_tag  <= dir_current_tag;
          r_hit         <= w_hit_path;
          r_final_state <= r_write ? ST_M : dir_current_state;
        end
        FILL_WAIT: begin
          if (fill_ack_valid) r_final_state <= r_write ? ST_M : fill_ack_state;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next   = r_state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_hit        = 1'b0;
    rsp_state      = ST_I;
    wb_valid       = 1'b0;
    wb_addr        = '0;
    fill_valid     = 1'b0;
    fill_addr      = '0;
    fill_excl      = 1'b0;
    dir_index      = r_index;
    dir_next_tag   = '0;
    dir_next_state = ST_I;
    dir_write      = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        dir_index = w_req_index;
        if (req_valid) w_state_next = LOOKUP;
      end
      LOOKUP: w_state_next = COMPARE;
      COMPARE: begin
        if (w_hit_path) begin
          w_state_next = RESP;
          if (r_write && (dir_current_state == ST_E)) begin
            dir_write      = 1'b1;
            dir_next_tag   = r_tag;
            dir_next_state = ST_M;
          end
        end else if (!w_hit && (dir_current_state == ST_M)) begin
          w_state_next = WB;
        end else begin
          w_state_next = FILL_REQ;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        wb_addr  = {r_victim_tag, r_index, ZERO_OFFSET};
        if (wb_ready) w_state_next = FILL_REQ;
      end
      FILL_REQ: begin
        fill_valid = 1'b1;
        fill_addr  = {r_tag, r_index, ZERO_OFFSET};
        fill_excl  = r_write;
        if (fill_ready) w_state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (fill_ack_valid) w_state_next = UPDATE;
      end
      UPDATE: begin
        dir_write      = 1'b1;
        dir_next_tag   = r_tag;
        dir_next_state = r_final_state;
        w_state_next   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = r_hit;
        rsp_state = r_final_state;
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end
endmodule
